// File: rtl/cu_int_capture.sv
// rtl/cu_int_capture.sv - multi-channel interrupt capture with edge/level latching, I-flag masking and priority select
// Optional build macro: CU_INT_HOLDOFF_EN (post-service request suppression counter)
module cu_int_capture #(
    parameter int             NCH         = 2,
    parameter logic [NCH-1:0] EDGE_MODE   = NCH'(2'b01),
    parameter logic [NCH-1:0] NMASK       = NCH'(2'b01),
    parameter int             SYNC_STAGES = 2,
    parameter int             HOLDOFF_CYC = 2,
    localparam int            IDW         = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NCH-1:0] b_int,
    input  logic           i_flg,
    input  logic           sd_vld,
    input  logic [IDW-1:0] sd_id,
    output logic [NCH-1:0] int_flg,
    output logic           req,
    output logic [IDW-1:0] req_id
);

    logic [NCH-1:0]     sync_q [SYNC_STAGES];
    logic [NCH-1:0]     s;
    logic [NCH-1:0]     p;
    logic [NCH-1:0]     fall;
    logic [NCH-1:0]     sd_hit;
    logic [NCH-1:0]     pend;
    logic [NCH-1:0]     pend_nxt;
    logic [NCH-1:0]     elig;
    logic [SYNC_STAGES:0] warm;
    logic [IDW-1:0]     top_id;
    logic               any_elig;
    logic               hold_block;
    logic               req_q;
    logic [IDW-1:0]     req_id_q;

    // Synchroniser and previous-sample flops reset high so reset release never looks like an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < SYNC_STAGES; j++) begin
                sync_q[j] <= '1;
            end
            p    <= '1;
            warm <= '0;
        end else begin
            sync_q[0] <= b_int;
            for (int j = 1; j < SYNC_STAGES; j++) begin
                sync_q[j] <= sync_q[j-1];
            end
            p    <= s;
            warm <= {warm[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // Edges are only trusted once both s and p hold real post-reset samples; a line held low
    // across reset therefore is not re-captured.
    assign fall = p & ~s & {NCH{warm[SYNC_STAGES]}};

    always_comb begin
        sd_hit = '0;
        for (int i = 0; i < NCH; i++) begin
            sd_hit[i] = sd_vld && (sd_id == IDW'(i));
        end
    end

    // Set has priority over service-done clear so a fresh edge is never lost.
    always_comb begin
        pend_nxt = '0;
        for (int i = 0; i < NCH; i++) begin
            if (EDGE_MODE[i]) begin
                pend_nxt[i] = fall[i] | (pend[i] & ~sd_hit[i]);
            end else begin
                pend_nxt[i] = ~s[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend <= '0;
        end else begin
            pend <= pend_nxt;
        end
    end

    assign elig     = pend & (NMASK | {NCH{~i_flg}});
    assign any_elig = |elig;

    always_comb begin
        top_id = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (elig[i]) begin
                top_id = IDW'(i);
            end
        end
    end

`ifdef CU_INT_HOLDOFF_EN
    localparam int HW = $clog2(HOLDOFF_CYC + 1);

    logic [HW-1:0] hold_cnt;
    logic [HW-1:0] hold_nxt;
    logic          sd_accept;

    assign sd_accept = |(sd_hit & pend);

    always_comb begin
        hold_nxt = hold_cnt;
        if (sd_accept) begin
            hold_nxt = HW'(HOLDOFF_CYC);
        end else if (hold_cnt != '0) begin
            hold_nxt = hold_cnt - HW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt <= '0;
        end else begin
            hold_cnt <= hold_nxt;
        end
    end

    // Request is held off exactly while the counter register is non-zero.
    assign hold_block = (hold_nxt != '0);
`else
    assign hold_block = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            req_q    <= 1'b0;
            req_id_q <= '0;
        end else begin
            req_q    <= any_elig & ~hold_block;
            req_id_q <= (any_elig & ~hold_block) ? top_id : '0;
        end
    end

    assign int_flg = pend;
    assign req     = req_q;
    assign req_id  = req_id_q;

endmodule

// File: tb/tb_cu_int_capture.sv
// tb/tb_cu_int_capture.sv - directed table-driven bench for cu_int_capture
module tb_cu_int_capture;

    typedef struct {
        logic [1:0] b;
        logic       i;
        logic       sdv;
        logic       sdid;
        logic [1:0] e_int;
        logic       e_req;
        logic       e_id;
    } vec_t;

    logic       clk;
    logic       rst;
    logic [1:0] b_int;
    logic       i_flg;
    logic       sd_vld;
    logic [0:0] sd_id;
    logic [1:0] int_flg;
    logic       req;
    logic [0:0] req_id;

    int   n_chk;
    int   n_fail;
    vec_t vt [64];
    int   nv;

    cu_int_capture #(
        .NCH        (2),
        .EDGE_MODE  (2'b01),
        .NMASK      (2'b01),
        .SYNC_STAGES(2),
        .HOLDOFF_CYC(3)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .b_int  (b_int),
        .i_flg  (i_flg),
        .sd_vld (sd_vld),
        .sd_id  (sd_id),
        .int_flg(int_flg),
        .req    (req),
        .req_id (req_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic chk(input string nm, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic add(input logic [1:0] b, input logic i, input logic sdv, input logic sdid,
                       input logic [1:0] ei, input logic er, input logic eid);
        vt[nv] = '{b: b, i: i, sdv: sdv, sdid: sdid, e_int: ei, e_req: er, e_id: eid};
        nv++;
    endtask

    task automatic sd_pulse(input logic id);
        sd_vld = 1'b1;
        sd_id  = id;
        tick(1);
        sd_vld = 1'b0;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        nv     = 0;
        rst    = 1'b1;
        b_int  = 2'b11;
        i_flg  = 1'b0;
        sd_vld = 1'b0;
        sd_id  = 1'b0;

        // idle, then channel 0 edge capture and service with line held low
        for (int k = 0; k < 10; k++) add(2'b11, 0, 0, 0, 2'b00, 0, 0);
        add(2'b10, 0, 0, 0, 2'b00, 0, 0);
        add(2'b10, 0, 0, 0, 2'b00, 0, 0);
        add(2'b10, 0, 0, 0, 2'b01, 0, 0);
        add(2'b10, 0, 0, 0, 2'b01, 1, 0);
        add(2'b10, 0, 0, 0, 2'b01, 1, 0);
        add(2'b10, 0, 0, 0, 2'b01, 1, 0);
        add(2'b10, 0, 1, 0, 2'b00, 1, 0);
        add(2'b10, 0, 0, 0, 2'b00, 0, 0);
        add(2'b10, 0, 0, 0, 2'b00, 0, 0);
        add(2'b11, 0, 0, 0, 2'b00, 0, 0);
        add(2'b11, 0, 0, 0, 2'b00, 0, 0);
        add(2'b11, 0, 0, 0, 2'b00, 0, 0);
        // level channel 1 under mask
        add(2'b01, 1, 0, 0, 2'b00, 0, 0);
        add(2'b01, 1, 0, 0, 2'b00, 0, 0);
        add(2'b01, 1, 0, 0, 2'b10, 0, 0);
        add(2'b01, 1, 0, 0, 2'b10, 0, 0);
        add(2'b01, 0, 0, 0, 2'b10, 1, 1);
        add(2'b01, 0, 1, 1, 2'b10, 1, 1);
        add(2'b11, 0, 0, 0, 2'b10, 1, 1);
        add(2'b11, 0, 0, 0, 2'b10, 1, 1);
        add(2'b11, 0, 0, 0, 2'b00, 1, 1);
        add(2'b11, 0, 0, 0, 2'b00, 0, 0);
        // priority with both lines low
        add(2'b00, 0, 0, 0, 2'b00, 0, 0);
        add(2'b00, 0, 0, 0, 2'b00, 0, 0);
        add(2'b00, 0, 0, 0, 2'b11, 0, 0);
        add(2'b00, 0, 0, 0, 2'b11, 1, 0);
        add(2'b00, 0, 1, 0, 2'b10, 1, 0);
        add(2'b00, 0, 0, 0, 2'b10, 1, 1);
        add(2'b11, 0, 0, 0, 2'b10, 1, 1);
        add(2'b11, 0, 0, 0, 2'b10, 1, 1);
        add(2'b11, 0, 0, 0, 2'b00, 1, 1);
        add(2'b11, 0, 1, 1, 2'b00, 0, 0);

        tick(2);
        chk("reset int_flg", int'(int_flg), 0);
        chk("reset req", int'(req), 0);
        chk("reset req_id", int'(req_id), 0);
        rst = 1'b0;

        for (int r = 0; r < nv; r++) begin
            b_int  = vt[r].b;
            i_flg  = vt[r].i;
            sd_vld = vt[r].sdv;
            sd_id  = vt[r].sdid;
            tick(1);
            chk($sformatf("row%0d int_flg", r), int'(int_flg), int'(vt[r].e_int));
            chk($sformatf("row%0d req", r), int'(req), int'(vt[r].e_req));
            chk($sformatf("row%0d req_id", r), int'(req_id), int'(vt[r].e_id));
        end
        sd_vld = 1'b0;

        // set/clear collision on channel 0 while already pending
        b_int = 2'b10;
        tick(3);
        chk("coll first capture", int'(int_flg), 1);
        b_int = 2'b11;
        tick(3);
        chk("coll still pending", int'(int_flg), 1);
        b_int = 2'b10;
        tick(2);
        sd_pulse(1'b0);
        chk("coll set wins int_flg", int'(int_flg), 1);
        tick(1);
        chk("coll req after", int'(req), 1);
        sd_pulse(1'b0);
        chk("coll cleared", int'(int_flg), 0);
        tick(1);
        chk("coll req cleared", int'(req), 0);
        b_int = 2'b11;
        tick(3);

        // reset mid-operation with line held low
        b_int = 2'b10;
        tick(4);
        chk("rst pre int_flg", int'(int_flg), 1);
        chk("rst pre req", int'(req), 1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("rst mid int_flg", int'(int_flg), 0);
        chk("rst mid req", int'(req), 0);
        chk("rst mid req_id", int'(req_id), 0);
        for (int k = 0; k < 6; k++) begin
            tick(1);
            chk($sformatf("rst held low int_flg c%0d", k), int'(int_flg), 0);
            chk($sformatf("rst held low req c%0d", k), int'(req), 0);
        end
        b_int = 2'b11;
        tick(3);
        b_int = 2'b10;
        tick(3);
        chk("rst new edge int_flg", int'(int_flg), 1);
        tick(1);
        chk("rst new edge req", int'(req), 1);
        sd_pulse(1'b0);
        b_int = 2'b11;
        tick(3);
        chk("rst cleanup", int'(int_flg), 0);

`ifdef CU_INT_HOLDOFF_EN
        b_int = 2'b00;
        tick(4);
        chk("hold both pending", int'(int_flg), 3);
        chk("hold pre req_id", int'(req_id), 0);
        sd_pulse(1'b0);
        chk("hold req c1", int'(req), 0);
        tick(1);
        chk("hold req c2", int'(req), 0);
        tick(1);
        chk("hold req c3", int'(req), 0);
        chk("hold req_id c3", int'(req_id), 0);
        tick(1);
        chk("hold release req", int'(req), 1);
        chk("hold release req_id", int'(req_id), 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cu_int_capture.md
# cu_int_capture

Parametrised, multi-channel interrupt capture unit for the CPU control unit. It is the successor to the fixed two-line NMI/IRQ capture. It synchronises N active-low interrupt lines and latches each one per channel, either edge-captured or level-followed. It applies the I-flag mask to maskable channels, selects the highest-priority pending request, and clears edge latches through a service-done handshake from the control signal generator.

## Interface
- NCH, default 2: number of interrupt channels (≥1). Channel 0 has the highest priority.
- EDGE_MODE, default 2'b01: per-channel mode. 1 = falling-edge capture (NMI-like); 0 = level (IRQ-like).
- NMASK, default 2'b01: per-channel non-maskable flag. 1 = ignores i_flg.
- SYNC_STAGES, default 2: synchroniser depth (≥1).
- HOLDOFF_CYC, default 2: post-service request suppression in cycles (≥1). Used only with CU_INT_HOLDOFF_EN.
- Clocking and reset: one clock; reset is synchronous and active-high.
- clk, input, 1: CPU clock.
- rst, input, 1: synchronous active-high reset.
- b_int, input, NCH: active-low interrupt lines, asynchronous to clk.
- i_flg, input, 1: processor I flag. 1 = maskable channels blocked.
- sd_vld, input, 1: service-done strobe, one cycle.
- sd_id, input, $clog2(NCH) (min 1): channel being serviced.
- int_flg, output, NCH: captured pending flags, unmasked view.
- req, output, 1: an unmasked pending channel exists.
- req_id, output, $clog2(NCH) (min 1): highest-priority unmasked pending channel.

## Operation
- Synchroniser:
  - Each b_int bit passes through SYNC_STAGES flops. Output s[i].
  - p[i] holds the previous s[i].
- Edge channel:
  - pend[i] sets when p[i]=1 and s[i]=0 (falling edge).
  - pend[i] clears on sd_vld with sd_id==i.
  - If set and clear occur in the same cycle, set wins: no event is lost.
  - A line held low yields exactly one capture.
- Level channel:
  - pend[i] = ~s[i], registered.
  - sd_vld has no effect; the source must deassert to clear.
- int_flg = pend, registered.
- Eligibility: elig[i] = pend[i] & (NMASK[i] | ~i_flg).
- Priority:
  - req_id = lowest index i with elig[i]=1.
  - req = |elig. Both are registered.
  - When req=0, req_id holds 0.
- Masking never clears a pending flag. A masked edge capture stays pending until i_flg=0 and it is serviced.
- Ignored service-done strobes: sd_vld with sd_id ≥ NCH, and sd_vld on a non-pending channel.

## Timing
- Reset values:
  - All synchroniser flops and p = 1 (inactive), so there is no spurious edge on reset release.
  - pend, int_flg = 0; req = 0; req_id = 0; holdoff counter = 0.
- Reset mid-operation discards all pending captures. An edge already completed before reset is not re-detected unless the line returns high and falls again.
- Latency from b_int being sampled low at edge 0:
  - s low after edge SYNC_STAGES−1.
  - int_flg high after edge SYNC_STAGES.
  - req/req_id valid after edge SYNC_STAGES+1.
  - With defaults: int_flg at cycle 2, req at cycle 3.
- Service-done: sd_vld at edge k gives int_flg[i]=0 after edge k and req updated after edge k+1.
- An i_flg change is reflected on req one cycle later.
- Minimum low pulse for guaranteed edge capture: 1 clk period, sampled.

## Configuration
- CU_INT_HOLDOFF_EN defined:
  - Any accepted sd_vld (valid id, channel pending) loads a counter with HOLDOFF_CYC.
  - While the counter is ≠0, req is forced to 0 and req_id to 0. The counter decrements each cycle.
  - Pending flags still capture normally.
  - Purpose: guarantees at least one instruction fetch between back-to-back interrupts.
- CU_INT_HOLDOFF_EN undefined: no counter exists. req follows elig with one-cycle latency, and HOLDOFF_CYC is unused.

## Test plan
1. Defaults. Release rst, all b_int=1 → int_flg=0 and req=0 for 10 cycles. Then drive b_int[0]=0 → int_flg=2'b01 at cycle 2, req=1 and req_id=0 at cycle 3. Hold low 20 cycles, pulse sd_vld with sd_id=0 → int_flg=0 and req=0 two cycles later, with no re-capture.
2. Level masking. i_flg=1, b_int[1]=0 → int_flg=2'b10 and req=0. Set i_flg=0 → req=1, req_id=1 next cycle. sd_vld with sd_id=1 → int_flg unchanged. b_int[1]=1 → int_flg=0 at cycle 2.
3. Priority. Both lines low in the same cycle with i_flg=0 → req_id=0. After servicing channel 0 → req_id=1.
4. Set/clear collision. A new falling edge on channel 0 reaches detection in the same cycle as sd_vld with sd_id=0 → int_flg[0] stays 1.
5. Reset mid-operation. Channel 0 pending and rst pulsed for 1 cycle → all outputs 0. b_int[0] held low through reset → no capture.
6. CU_INT_HOLDOFF_EN with HOLDOFF_CYC=3. Both channels pending, service channel 0 → req=0 for 3 cycles, then req=1 with req_id=1.
